// File: rtl/traffic_demand_detect.sv
// -----------------------------------------------------------------------------
// traffic_demand_detect
//
// Front end of the traffic light controller. The raw vehicle-loop sensors of
// the main and first streets are turned into clean per-street queue counts. The
// controller's green outputs come back in and retire queued vehicles at a
// fixed service rate.
//
// Each street has the same pipeline, and the two streets are fully independent:
//   sensor -> 2-flop synchronizer -> debounce filter -> rising-edge arrival
//   green  -> serve timer -> departure pulse
//   arrival/departure -> saturating queue counter + sticky overflow flag
//
// Ports (top):
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset (0 = reset)
//   sense_main   raw loop sensor, main street (asynchronous to clk)
//   sense_first  raw loop sensor, first street (asynchronous to clk)
//   green_main   green light of the main street, from the controller
//   green_first  green light of the first street, from the controller
//   clr_ovf      synchronous clear of both overflow flags
//   waiting_main / waiting_first  queue non-zero
//   queue_main / queue_first      vehicle counts (CNT_W bits)
//   ovf_main / ovf_first          sticky: arrival lost at a full queue
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// traffic_demand_street
//
// One street's demand pipeline.
//   i_sense    raw asynchronous loop sensor
//   i_green    green light of this street
//   i_clr_ovf  synchronous overflow clear
//   o_waiting  queue non-zero (decoded straight from the queue register)
//   o_queue    queued vehicle count
//   o_ovf      sticky overflow flag
// -----------------------------------------------------------------------------
module traffic_demand_street #(
  parameter int DEB_CYCLES   = 3,
  parameter int CNT_W        = 4,
  parameter int SERVE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sense,
  input  logic             i_green,
  input  logic             i_clr_ovf,
  output logic             o_waiting,
  output logic [CNT_W-1:0] o_queue,
  output logic             o_ovf
);

  // Counter widths, kept at least one bit wide so DEB_CYCLES/SERVE_CYCLES of 1
  // still elaborate cleanly.
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SRV_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] Q_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] Q_ZERO   = {CNT_W{1'b0}};

  logic             r_sync1;
  logic             r_sync2;
  logic             r_filt;
  logic             r_filt_d;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [SRV_W-1:0] r_serve_tmr;
  logic             r_dep;
  logic [CNT_W-1:0] r_queue;
  logic             r_ovf;

  logic             w_arrival;
  logic             w_dep_ok;
  logic [CNT_W-1:0] w_queue_nxt;
  logic             w_ovf_set;

  // Two-flop synchronizer for the asynchronous loop sensor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sense;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce filter: the filtered level follows the synchronized level only
  // after it has disagreed for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt    <= 1'b0;
      r_filt_d  <= 1'b0;
      r_deb_cnt <= {DEB_W{1'b0}};
    end else begin
      r_filt_d <= r_filt;
      if (r_sync2 != r_filt) begin
        if (r_deb_cnt == DEB_LAST) begin
          r_filt    <= r_sync2;
          r_deb_cnt <= {DEB_W{1'b0}};
        end else begin
          r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
      end else begin
        // Any agreement restarts the count, so a short glitch never accumulates.
        r_deb_cnt <= {DEB_W{1'b0}};
      end
    end
  end

  // A car sitting on the loop produces exactly one arrival, on the rising edge.
  assign w_arrival = r_filt & ~r_filt_d;

  // Serve timer: one departure every SERVE_CYCLES of continuous green. Dropping
  // green throws away any partial service time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_serve_tmr <= {SRV_W{1'b0}};
      r_dep       <= 1'b0;
    end else if (i_green) begin
      if (r_serve_tmr == SRV_LAST) begin
        r_serve_tmr <= {SRV_W{1'b0}};
        r_dep       <= (r_queue != Q_ZERO);
      end else begin
        r_serve_tmr <= r_serve_tmr + SRV_W'(1);
        r_dep       <= 1'b0;
      end
    end else begin
      r_serve_tmr <= {SRV_W{1'b0}};
      r_dep       <= 1'b0;
    end
  end

  // Next queue value. Simultaneous arrival and departure cancel. The departure
  // is re-qualified against the current count so that back-to-back departures
  // with a one-cycle service time can never wrap the counter below zero.
  always_comb begin
    w_dep_ok    = r_dep & (r_queue != Q_ZERO);
    w_queue_nxt = r_queue;
    w_ovf_set   = 1'b0;
    case ({w_arrival, w_dep_ok})
      2'b10: begin
        if (r_queue == Q_MAX) begin
          w_queue_nxt = r_queue;
          w_ovf_set   = 1'b1;
        end else begin
          w_queue_nxt = r_queue + CNT_W'(1);
          w_ovf_set   = 1'b0;
        end
      end
      2'b01: begin
        w_queue_nxt = r_queue - CNT_W'(1);
      end
      default: begin
        w_queue_nxt = r_queue;
      end
    endcase
  end

  // Queue register and sticky overflow flag. When a lost arrival and a clear
  // happen in the same cycle, the lost arrival wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_queue <= Q_ZERO;
      r_ovf   <= 1'b0;
    end else begin
      r_queue <= w_queue_nxt;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  assign o_queue   = r_queue;
  assign o_waiting = (r_queue != Q_ZERO);
  assign o_ovf     = r_ovf;

endmodule

`ifdef FORMAL
// -----------------------------------------------------------------------------
// traffic_demand_detect_chk
//
// Queue invariants for one street, ignored while reset is asserted.
//   queue    queue count of the street
//   waiting  waiting flag of the street
// -----------------------------------------------------------------------------
module traffic_demand_detect_chk #(
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             rst,
  input logic [CNT_W-1:0] queue,
  input logic             waiting
);

  localparam logic [CNT_W-1:0] Q_MAX = {CNT_W{1'b1}};

  a_queue_range : assert property (@(posedge clk) disable iff (!rst)
    queue <= Q_MAX);

  a_queue_step : assert property (@(posedge clk) disable iff (!rst)
    $past(rst) |-> ((queue == $past(queue)) ||
                    (queue == $past(queue) + CNT_W'(1)) ||
                    (queue == $past(queue) - CNT_W'(1))));

  a_waiting : assert property (@(posedge clk) disable iff (!rst)
    waiting == (queue != {CNT_W{1'b0}}));

endmodule
`endif

// -----------------------------------------------------------------------------
// traffic_demand_detect (top): two independent street pipelines.
// -----------------------------------------------------------------------------
module traffic_demand_detect #(
  parameter int DEB_CYCLES   = 3,
  parameter int CNT_W        = 4,
  parameter int SERVE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sense_main,
  input  logic             sense_first,
  input  logic             green_main,
  input  logic             green_first,
  input  logic             clr_ovf,
  output logic             waiting_main,
  output logic             waiting_first,
  output logic [CNT_W-1:0] queue_main,
  output logic [CNT_W-1:0] queue_first,
  output logic             ovf_main,
  output logic             ovf_first
);

  traffic_demand_street #(
    .DEB_CYCLES   (DEB_CYCLES),
    .CNT_W        (CNT_W),
    .SERVE_CYCLES (SERVE_CYCLES)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .i_sense   (sense_main),
    .i_green   (green_main),
    .i_clr_ovf (clr_ovf),
    .o_waiting (waiting_main),
    .o_queue   (queue_main),
    .o_ovf     (ovf_main)
  );

  traffic_demand_street #(
    .DEB_CYCLES   (DEB_CYCLES),
    .CNT_W        (CNT_W),
    .SERVE_CYCLES (SERVE_CYCLES)
  ) u_first (
    .clk       (clk),
    .rst       (rst),
    .i_sense   (sense_first),
    .i_green   (green_first),
    .i_clr_ovf (clr_ovf),
    .o_waiting (waiting_first),
    .o_queue   (queue_first),
    .o_ovf     (ovf_first)
  );

`ifdef FORMAL
  traffic_demand_detect_chk #(.CNT_W(CNT_W)) u_chk_main (
    .clk     (clk),
    .rst     (rst),
    .queue   (queue_main),
    .waiting (waiting_main)
  );

  traffic_demand_detect_chk #(.CNT_W(CNT_W)) u_chk_first (
    .clk     (clk),
    .rst     (rst),
    .queue   (queue_first),
    .waiting (waiting_first)
  );
`endif

endmodule

// File: tb/tb_traffic_demand_detect.sv
// -----------------------------------------------------------------------------
// Testbench for traffic_demand_detect at its default parameters
// (DEB_CYCLES=3, CNT_W=4, SERVE_CYCLES=4). Inputs change 1 time unit after a
// rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_traffic_demand_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       sense_main;
  logic       sense_first;
  logic       green_main;
  logic       green_first;
  logic       clr_ovf;
  logic       waiting_main;
  logic       waiting_first;
  logic [3:0] queue_main;
  logic [3:0] queue_first;
  logic       ovf_main;
  logic       ovf_first;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       sm;
    logic       sf;
    logic       gm;
    logic       gf;
    logic       clr;
    logic [3:0] qm;
    logic [3:0] qf;
    logic       om;
    logic       ofl;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  traffic_demand_detect dut (
    .clk           (clk),
    .rst           (rst),
    .sense_main    (sense_main),
    .sense_first   (sense_first),
    .green_main    (green_main),
    .green_first   (green_first),
    .clr_ovf       (clr_ovf),
    .waiting_main  (waiting_main),
    .waiting_first (waiting_first),
    .queue_main    (queue_main),
    .queue_first   (queue_first),
    .ovf_main      (ovf_main),
    .ovf_first     (ovf_first)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eqm, input logic [3:0] eqf,
                       input logic eom, input logic eof);
    logic [13:0] act;
    logic [13:0] expv;
    act  = {queue_main, queue_first, waiting_main, waiting_first, ovf_main, ovf_first};
    expv = {eqm, eqf, (eqm != 4'd0), (eqf != 4'd0), eom, eof};
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got qm=%0d qf=%0d wm=%b wf=%b om=%b of=%b, expected qm=%0d qf=%0d wm=%b wf=%b om=%b of=%b",
               name, queue_main, queue_first, waiting_main, waiting_first, ovf_main, ovf_first,
               eqm, eqf, (eqm != 4'd0), (eqf != 4'd0), eom, eof);
    end
  endtask

  task automatic add(input logic sm, input logic sf, input logic gm, input logic gf,
                     input logic clr, input logic [3:0] qm, input logic [3:0] qf,
                     input logic om, input logic ofl);
    vec_t v;
    v.sm = sm; v.sf = sf; v.gm = gm; v.gf = gf; v.clr = clr;
    v.qm = qm; v.qf = qf; v.om = om; v.ofl = ofl;
    tbl.push_back(v);
  endtask

  // One clean arrival: sensor high 5 cycles (counted at the 6th edge), then
  // low long enough for the filter to fall again.
  task automatic pulse(input bit first);
    if (first) sense_first = 1'b1; else sense_main = 1'b1;
    repeat (5) tick();
    if (first) sense_first = 1'b0; else sense_main = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;

    // Reset held with active inputs.
    rst = 1'b0; sense_main = 1'b1; sense_first = 1'b0;
    green_main = 1'b0; green_first = 1'b1; clr_ovf = 1'b0;
    repeat (3) tick();
    check("reset_hold", 4'd0, 4'd0, 1'b0, 1'b0);

    // Table: edge 0 is the first edge after release; sense_main held high.
    for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (i >= 5) ? 4'd1 : 4'd0, 4'd0, 1'b0, 1'b0);
    // Glitch: sense_first high for 2 cycles only.
    for (int i = 0; i < 2; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
    // Long pulse: sense_first high 6 cycles, counted once at the 6th edge.
    for (int i = 0; i < 6; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, (i == 5) ? 4'd1 : 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0);

    rst = 1'b1; green_first = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      sense_main = tbl[i].sm; sense_first = tbl[i].sf;
      green_main = tbl[i].gm; green_first = tbl[i].gf; clr_ovf = tbl[i].clr;
      tick();
      check($sformatf("vec%0d", i), tbl[i].qm, tbl[i].qf, tbl[i].om, tbl[i].ofl);
    end

    // Service: build queue_main = 3, then green for 10 cycles.
    sense_main = 1'b0; sense_first = 1'b0;
    repeat (6) tick();
    check("svc_pre", 4'd1, 4'd1, 1'b0, 1'b0);
    pulse(1'b0);
    pulse(1'b0);
    check("svc_q3", 4'd3, 4'd1, 1'b0, 1'b0);
    green_main = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      e = (j < 4) ? 4'd3 : ((j < 8) ? 4'd2 : 4'd1);
      check($sformatf("svc_g%0d", j), e, 4'd1, 1'b0, 1'b0);
    end
    green_main = 1'b0;
    tick();
    check("svc_goff", 4'd1, 4'd1, 1'b0, 1'b0);
    green_main = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("svc_re%0d", j), 4'd1, 4'd1, 1'b0, 1'b0);
    end
    green_main = 1'b0;
    tick();
    check("svc_empty", 4'd0, 4'd1, 1'b0, 1'b0);

    // Simultaneous arrival and departure on first street.
    pulse(1'b1);
    check("sim_q2", 4'd0, 4'd2, 1'b0, 1'b0);
    sense_first = 1'b1;
    tick();                      // edge e: sensor sampled high
    green_first = 1'b1;          // green sampled from edge e+1
    for (int j = 1; j < 10; j++) begin
      tick();
      check($sformatf("sim_e%0d", j), 4'd0, (j < 9) ? 4'd2 : 4'd1, 1'b0, 1'b0);
    end
    green_first = 1'b0; sense_first = 1'b0;
    repeat (6) tick();
    check("sim_post", 4'd0, 4'd1, 1'b0, 1'b0);

    // Overflow on main: 16 arrivals, green off.
    for (int i = 1; i <= 16; i++) begin
      pulse(1'b0);
      check($sformatf("ovf_arr%0d", i), (i > 15) ? 4'd15 : 4'(i), 4'd1, (i == 16), 1'b0);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr", 4'd15, 4'd1, 1'b0, 1'b0);
    sense_main = 1'b1;
    repeat (5) tick();
    clr_ovf = 1'b1;              // same edge as the lost arrival
    tick();
    clr_ovf = 1'b0;
    check("ovf_set_wins", 4'd15, 4'd1, 1'b1, 1'b0);
    sense_main = 1'b0;
    repeat (6) tick();
    check("ovf_sticky", 4'd15, 4'd1, 1'b1, 1'b0);

    // Drain to 5 with the serve timer left at 2, then reset mid-operation.
    green_main = 1'b1;
    for (int j = 0; j < 42; j++) begin
      tick();
      if (j == 20) check("rst_drain", 4'd10, 4'd1, 1'b1, 1'b0);
    end
    check("rst_pre", 4'd5, 4'd1, 1'b1, 1'b0);
    sense_main = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_async", 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    check("rst_held", 4'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    // Green and sensor held high: arrival at edge 5, first departure at edge 8.
    for (int j = 0; j < 11; j++) begin
      tick();
      check($sformatf("rst_after%0d", j), (j >= 5 && j < 8) ? 4'd1 : 4'd0, 4'd0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/traffic_demand_detect.md
Name: traffic_demand_detect

Overview:
- Upstream stage of the traffic light controller.
- Converts raw, asynchronous vehicle-loop sensor signals for the main and first streets into clean per-street queue counts.
- Drives waiting_main and waiting_first into the controller.
- Uses the controller's green outputs as feedback to retire queued vehicles at a fixed service rate.

Parameters:
DEB_CYCLES, 3, consecutive synchronized cycles a sensor level must hold before the filtered level changes (>=1)
CNT_W, 4, queue counter width; maximum queue = 2^CNT_W-1
SERVE_CYCLES, 4, cycles of continuous green needed to retire one queued vehicle (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
sense_main  input  1  raw loop sensor, main street, asynchronous to clk
sense_first  input  1  raw loop sensor, first street, asynchronous to clk
green_main  input  1  green light of main street, from controller
green_first  input  1  green light of first street, from controller
clr_ovf  input  1  synchronous clear of both overflow flags
waiting_main  output  1  main queue non-zero
waiting_first  output  1  first queue non-zero
queue_main  output  CNT_W  main street vehicle count
queue_first  output  CNT_W  first street vehicle count
ovf_main  output  1  sticky: arrival lost at full main queue
ovf_first  output  1  sticky: arrival lost at full first queue

Behaviour:
- Reset is applied asynchronously while rst=0. During reset:
  - All registers go to 0: synchronizers, filtered levels, debounce counters, serve timers, queues, overflow flags.
  - All outputs are 0.
  - Reset mid-operation discards queued vehicles.
  - The first active edge is the first rising clk with rst=1.
- Per-street logic is identical and fully independent. Main and first are described once below.
- Synchronizer: 2-flop chain on sense_x; s2 is the synchronized level.
- Debounce:
  - deb_cnt counts while s2 != filt and resets to 0 whenever s2 == filt.
  - When s2 != filt and deb_cnt == DEB_CYCLES-1, filt takes s2 and deb_cnt returns to 0.
  - A pulse on s2 shorter than DEB_CYCLES cycles never changes filt.
- Arrival: pulse on filt rising edge (filt=1, filt_d=0). A car sitting on the loop counts once. A falling edge has no effect.
- Serve timer:
  - While green_x=1, serve_tmr increments each cycle.
  - At serve_tmr == SERVE_CYCLES-1 it wraps to 0 and raises a departure pulse, but only if the queue is > 0.
  - When green_x=0, serve_tmr is forced to 0, so partial green time is not carried over.
- Queue update, one edge after the pulse:
  - Arrival only: queue+1.
  - Departure only: queue-1.
  - Both: unchanged.
  - Arrival at 2^CNT_W-1 without a departure: queue holds (saturates) and ovf_x is set.
  - A departure is never generated at queue 0, so there is no underflow.
- ovf_x: sticky. Cleared by clr_ovf=1 at an edge. If a set condition occurs in the same cycle as clr_ovf, set wins.
- waiting_x = (queue_x != 0), combinational from the queue register, so there are no extra cycles.
- Latency, with sense_x first sampled high at edge 0 and held:
  - s2=1 after edge 1.
  - filt=1 after edge 1+DEB_CYCLES.
  - queue increments and waiting rises after edge 2+DEB_CYCLES (edge 5 at defaults).
- Departure latency: green_x first sampled high at edge k, queue>0 → queue decrements at edge k+SERVE_CYCLES (edge k+4 at defaults). Further departures follow every SERVE_CYCLES edges while green stays high.
- Both streets may update in the same cycle. There is no cross-coupling.
- Checks under FORMAL, disabled while rst=0:
  - queue_x never exceeds 2^CNT_W-1.
  - queue_x changes by at most 1 per cycle.
  - waiting_x == (queue_x != 0).

Test Plan:
- Reset: hold rst=0 with sense_main=1 and green_first=1 → all outputs 0. Release, hold sense_main=1 → queue_main=1 and waiting_main=1 after edge 5; stays 1 while sense_main stays high.
- Glitch: sense_first high for 2 cycles, then low → queue_first stays 0. High for 6 cycles → queue_first=1 exactly once.
- Service: queue_main=3, green_main high for 10 cycles → queue_main 2, 1 at edges +4, +8, still 1 at +10. Drop green, reassert for 4 cycles → queue 0 and waiting_main falls.
- Simultaneous: queue_first=2, arrival pulse on the same cycle as a departure → queue_first stays 2.
- Overflow: 16 separated arrivals on main with green off → queue_main saturates at 15 and ovf_main=1. clr_ovf with no arrival → ovf_main=0. clr_ovf in the same cycle as another lost arrival → ovf_main stays 1.
- Reset mid-operation: queue_main=5, green_main high with serve_tmr=2, drive rst=0 between edges → queue, waiting and ovf go to 0 immediately. After release, the first departure needs a full 4 green cycles.
